// File: rtl/dt_tree_walker.sv
// dt_tree_walker: decision-tree traversal engine.
// Walks nodes from a synchronous node ROM. At each internal node it asks the
// feature selector for one feature and branches on a signed compare against
// the node threshold, until a leaf supplies the class.
// Optional feature: define DT_PATH_TRACE_EN to add the path_bits/path_depth
// trace outputs.
module dt_tree_walker #(
   parameter int ADDR_W      = 8,
   parameter int CLASS_W     = 4,
   parameter int ROOT_ADDR   = 0,
   parameter int MAX_DEPTH   = 16,
   parameter int SEL_TIMEOUT = 15,
   localparam int NODE_W     = 2*ADDR_W+36
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic [CLASS_W-1:0] class_out,
   output logic               err,
   output logic [1:0]         err_code,
   output logic [ADDR_W-1:0]  node_addr,
   input  logic [NODE_W-1:0]  node_rdata,
   output logic               sel_valid,
   output logic [2:0]         sel_feature_id,
   input  logic [31:0]        sel_feature,
   input  logic               sel_valid_out,
   input  logic               sel_error
`ifdef DT_PATH_TRACE_EN
   ,
   output logic [MAX_DEPTH-1:0] path_bits,
   output logic [7:0]           path_depth
`endif
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FETCH    = 2'd1,
      DECODE   = 2'd2,
      WAIT_SEL = 2'd3
   } state_t;

   localparam logic [1:0] CODE_SEL = 2'b01;
   localparam logic [1:0] CODE_DEPTH = 2'b10;
   localparam logic [1:0] CODE_TMO = 2'b11;

   state_t              state, state_nxt;
   logic                busy_nxt, done_nxt, err_nxt, sel_valid_nxt;
   logic [CLASS_W-1:0]  class_nxt;
   logic [1:0]          err_code_nxt;
   logic [ADDR_W-1:0]   node_addr_nxt;
   logic [2:0]          fid_nxt;
   logic [7:0]          depth, depth_nxt, depth_inc;
   logic [7:0]          tmo, tmo_nxt;
   logic [31:0]         thr, thr_nxt;
   logic [ADDR_W-1:0]   left, left_nxt, right, right_nxt;
   logic                go_right;
`ifdef DT_PATH_TRACE_EN
   logic [MAX_DEPTH-1:0] trace, trace_nxt;
`endif

   // Equality goes left, so only a strictly greater feature branches right.
   assign go_right  = $signed(sel_feature) > $signed(thr);
   assign depth_inc = depth + 8'd1;

   // Next-state and next-register values for the whole traversal.
   always_comb begin
      // NOTE: every target gets a default first so no path can infer a latch.
      state_nxt     = state;
      busy_nxt      = busy;
      done_nxt      = 1'b0;
      err_nxt       = 1'b0;
      sel_valid_nxt = 1'b0;
      class_nxt     = class_out;
      err_code_nxt  = err_code;
      node_addr_nxt = node_addr;
      fid_nxt       = sel_feature_id;
      depth_nxt     = depth;
      tmo_nxt       = tmo;
      thr_nxt       = thr;
      left_nxt      = left;
      right_nxt     = right;
`ifdef DT_PATH_TRACE_EN
      trace_nxt     = trace;
`endif
      unique case (state)
         IDLE: begin
            if (start) begin
               node_addr_nxt = ADDR_W'(ROOT_ADDR);
               depth_nxt     = 8'd0;
               err_code_nxt  = 2'b00;
               busy_nxt      = 1'b1;
`ifdef DT_PATH_TRACE_EN
               trace_nxt     = '0;
`endif
               state_nxt     = FETCH;
            end
         end
         FETCH: state_nxt = DECODE;
         DECODE: begin
            if (node_rdata[NODE_W-1]) begin
               class_nxt = node_rdata[CLASS_W-1:0];
               done_nxt  = 1'b1;
               busy_nxt  = 1'b0;
               state_nxt = IDLE;
            end else begin
               thr_nxt       = node_rdata[31:0];
               fid_nxt       = node_rdata[34:32];
               left_nxt      = node_rdata[35 +: ADDR_W];
               right_nxt     = node_rdata[35+ADDR_W +: ADDR_W];
               sel_valid_nxt = 1'b1;
               tmo_nxt       = 8'd0;
               state_nxt     = WAIT_SEL;
            end
         end
         WAIT_SEL: begin
            if (sel_valid_out) begin
               if (sel_error) begin
                  err_nxt      = 1'b1;
                  err_code_nxt = CODE_SEL;
                  busy_nxt     = 1'b0;
                  state_nxt    = IDLE;
               end else begin
                  depth_nxt = depth_inc;
`ifdef DT_PATH_TRACE_EN
                  trace_nxt = trace | ({{(MAX_DEPTH-1){1'b0}}, go_right} << depth);
`endif
                  if (depth_inc == 8'(MAX_DEPTH)) begin
                     err_nxt      = 1'b1;
                     err_code_nxt = CODE_DEPTH;
                     busy_nxt     = 1'b0;
                     state_nxt    = IDLE;
                  end else begin
                     node_addr_nxt = go_right ? right : left;
                     state_nxt     = FETCH;
                  end
               end
            end else if (tmo == 8'(SEL_TIMEOUT-1)) begin
               err_nxt      = 1'b1;
               err_code_nxt = CODE_TMO;
               busy_nxt     = 1'b0;
               state_nxt    = IDLE;
            end else begin
               tmo_nxt = tmo + 8'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: registers update with non-blocking assignments only.
      if (rst) begin
         state          <= IDLE;
         busy           <= 1'b0;
         done           <= 1'b0;
         err            <= 1'b0;
         sel_valid      <= 1'b0;
         class_out      <= '0;
         err_code       <= 2'b00;
         node_addr      <= ADDR_W'(ROOT_ADDR);
         sel_feature_id <= 3'd0;
         depth          <= 8'd0;
         tmo            <= 8'd0;
         thr            <= 32'd0;
         left           <= '0;
         right          <= '0;
`ifdef DT_PATH_TRACE_EN
         trace          <= '0;
`endif
      end else begin
         state          <= state_nxt;
         busy           <= busy_nxt;
         done           <= done_nxt;
         err            <= err_nxt;
         sel_valid      <= sel_valid_nxt;
         class_out      <= class_nxt;
         err_code       <= err_code_nxt;
         node_addr      <= node_addr_nxt;
         sel_feature_id <= fid_nxt;
         depth          <= depth_nxt;
         tmo            <= tmo_nxt;
         thr            <= thr_nxt;
         left           <= left_nxt;
         right          <= right_nxt;
`ifdef DT_PATH_TRACE_EN
         trace          <= trace_nxt;
`endif
      end
   end

`ifdef DT_PATH_TRACE_EN
   assign path_bits  = trace;
   assign path_depth = depth;
`else
   // Path trace outputs are not built.
`endif

endmodule

// File: tb/tb_dt_tree_walker.sv
// Self-checking bench for dt_tree_walker: ROM and selector models plus a
// tree-walk reference model that predicts outcome, class and timing.
module tb_dt_tree_walker;

   localparam int ADDR_W  = 8;
   localparam int CLASS_W = 4;
   localparam int ROOT    = 0;
   localparam int MAXD    = 4;
   localparam int TMO     = 5;
   localparam int NODE_W  = 2*ADDR_W+36;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               start = 1'b0;
   logic               busy, done, err, sel_valid;
   logic [CLASS_W-1:0] class_out;
   logic [1:0]         err_code;
   logic [ADDR_W-1:0]  node_addr;
   logic [NODE_W-1:0]  node_rdata;
   logic [2:0]         sel_feature_id;
   logic [31:0]        sel_feature = '0;
   logic               sel_valid_out = 1'b0;
   logic               sel_error = 1'b0;
`ifdef DT_PATH_TRACE_EN
   logic [MAXD-1:0]    path_bits;
   logic [7:0]         path_depth;
`endif

   dt_tree_walker #(
      .ADDR_W(ADDR_W), .CLASS_W(CLASS_W), .ROOT_ADDR(ROOT),
      .MAX_DEPTH(MAXD), .SEL_TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .class_out(class_out), .err(err), .err_code(err_code),
      .node_addr(node_addr), .node_rdata(node_rdata),
      .sel_valid(sel_valid), .sel_feature_id(sel_feature_id),
      .sel_feature(sel_feature), .sel_valid_out(sel_valid_out),
      .sel_error(sel_error)
`ifdef DT_PATH_TRACE_EN
      , .path_bits(path_bits), .path_depth(path_depth)
`endif
   );

   always #5 clk = ~clk;

   // Environment: node ROM, per-feature values and selector behaviour.
   logic [NODE_W-1:0]  rom [256];
   logic signed [31:0] feat [8];
   bit                 err_mask [8];
   int                 lat = 1;
   bit                 mute = 1'b0;
   int                 cnt = 0;
   logic [2:0]         pid = '0;

   int n_vec = 0;
   int n_miss = 0;
   int last_class = 0;

   // Synchronous node ROM.
   always @(posedge clk) node_rdata <= rom[node_addr];

   // Selector model: answers each request lat cycles after sampling it.
   always @(posedge clk) begin
      sel_valid_out <= 1'b0;
      sel_error     <= 1'b0;
      if (rst) begin
         cnt <= 0;
      end else if (sel_valid && !mute) begin
         if (lat == 1) begin
            sel_valid_out <= 1'b1;
            sel_feature   <= feat[sel_feature_id];
            sel_error     <= err_mask[sel_feature_id];
         end else begin
            cnt <= lat - 1;
            pid <= sel_feature_id;
         end
      end else if (cnt == 1) begin
         sel_valid_out <= 1'b1;
         sel_feature   <= feat[pid];
         sel_error     <= err_mask[pid];
         cnt           <= 0;
      end else if (cnt > 1) begin
         cnt <= cnt - 1;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [NODE_W-1:0] mk_node(input int fid, input int thr, input int l, input int r);
      return {1'b0, 8'(r), 8'(l), 3'(fid), 32'(thr)};
   endfunction

   function automatic logic [NODE_W-1:0] mk_leaf(input int cls);
      return {1'b1, 19'd0, 32'(cls)};
   endfunction

   typedef struct {
      bit              is_err;
      int              cls;
      int              code;
      int              cyc;
      int              nreq;
      logic [MAXD-1:0] pbits;
      int              pdepth;
   } exp_t;

   // Reference walk. t is the cycle (after the start edge) on which the
   // current node is decoded; an internal node costs lat+3 cycles.
   function automatic exp_t model();
      exp_t e;
      int addr = ROOT;
      int t = 2;
      logic [NODE_W-1:0] n;
      int fid, resp;
      bit rgt;
      e.is_err = 0; e.cls = 0; e.code = 0; e.cyc = 0;
      e.nreq = 0; e.pbits = '0; e.pdepth = 0;
      for (int g = 0; g < 300; g++) begin
         n = rom[addr];
         if (n[NODE_W-1]) begin
            e.cls = int'(n[CLASS_W-1:0]);
            e.cyc = t;
            return e;
         end
         e.nreq++;
         e.is_err = 1;
         if (mute || lat >= TMO) begin
            e.code = 3; e.cyc = t + TMO;
            return e;
         end
         resp = t + lat + 1;
         fid  = int'(n[34:32]);
         if (err_mask[fid]) begin
            e.code = 1; e.cyc = resp;
            return e;
         end
         rgt = feat[fid] > $signed(n[31:0]);
         if (rgt) e.pbits[e.pdepth] = 1'b1;
         e.pdepth++;
         if (e.pdepth == MAXD) begin
            e.code = 2; e.cyc = resp;
            return e;
         end
         e.is_err = 0;
         addr = rgt ? int'(n[50:43]) : int'(n[42:35]);
         t = resp + 2;
      end
      return e;
   endfunction

   // One inference: start pulse, bounded wait, compare against the model.
   task automatic run_inf(input string tag, input bit poke);
      exp_t e;
      int cyc = 0;
      int nsv = 0;
      bit fin = 0;
      e = model();
      @(negedge clk) start = 1'b1;
      @(posedge clk) #1 start = 1'b0;
      while (cyc < 200 && !fin) begin
         @(posedge clk);
         cyc++;
         #1;
         if (cyc == 1) begin
            check({tag, ".busy"}, 64'(busy), 64'd1);
            if (poke) start = 1'b1;
         end
         if (cyc == 2) start = 1'b0;
         if (sel_valid) nsv++;
         if (done || err) fin = 1;
      end
      start = 1'b0;
      check({tag, ".finished"}, 64'(fin), 64'd1);
      check({tag, ".is_err"}, 64'(err), 64'(e.is_err));
      check({tag, ".done"}, 64'(done), 64'(!e.is_err));
      check({tag, ".cycles"}, 64'(cyc), 64'(e.cyc));
      check({tag, ".requests"}, 64'(nsv), 64'(e.nreq));
      check({tag, ".busy_end"}, 64'(busy), 64'd0);
      if (e.is_err) begin
         check({tag, ".err_code"}, 64'(err_code), 64'(e.code));
         check({tag, ".class_held"}, 64'(class_out), 64'(last_class));
      end else begin
         check({tag, ".class"}, 64'(class_out), 64'(e.cls));
         check({tag, ".err_code_clr"}, 64'(err_code), 64'd0);
         last_class = e.cls;
      end
`ifdef DT_PATH_TRACE_EN
      check({tag, ".path_bits"}, 64'(path_bits), 64'(e.pbits));
      check({tag, ".path_depth"}, 64'(path_depth), 64'(e.pdepth));
`endif
      @(posedge clk) #1;
      check({tag, ".pulse"}, 64'({done, err}), 64'd0);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, ".busy"}, 64'(busy), 64'd0);
      check({tag, ".done"}, 64'(done), 64'd0);
      check({tag, ".err"}, 64'(err), 64'd0);
      check({tag, ".sel_valid"}, 64'(sel_valid), 64'd0);
      check({tag, ".class"}, 64'(class_out), 64'd0);
      check({tag, ".err_code"}, 64'(err_code), 64'd0);
      check({tag, ".node_addr"}, 64'(node_addr), 64'(ROOT));
      check({tag, ".fid"}, 64'(sel_feature_id), 64'd0);
   endtask

   // Three-node tree: root fid2 threshold thr, left leaf 3, right leaf 7.
   task automatic small_tree(input int thr);
      rom[0] = mk_node(2, thr, 1, 2);
      rom[1] = mk_leaf(3);
      rom[2] = mk_leaf(7);
   endtask

   initial begin
      int v, pulses;
      for (int i = 0; i < 256; i++) rom[i] = mk_leaf(0);
      for (int i = 0; i < 8; i++) begin feat[i] = 0; err_mask[i] = 0; end

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check_reset_vals("reset");

      rom[0] = mk_leaf(5);
      run_inf("root_leaf", 0);

      small_tree(100);
      feat[2] = 100;  run_inf("thr_equal_left", 0);
      feat[2] = 101;  run_inf("thr_above_right", 0);
      small_tree(-5);
      feat[2] = -6;   run_inf("neg_left", 0);
      feat[2] = 0;    run_inf("neg_right", 0);

      err_mask[2] = 1; run_inf("sel_error", 0);
      err_mask[2] = 0; run_inf("after_sel_error", 0);

      rom[0] = mk_node(1, 0, 0, 0);
      run_inf("depth_limit", 0);

      small_tree(10);
      feat[2] = 20;
      mute = 1; run_inf("timeout", 0);
      mute = 0;
      lat = TMO - 1; run_inf("late_ok", 0);
      lat = TMO;     run_inf("late_timeout", 0);
      lat = 1;       run_inf("after_late", 0);
      run_inf("start_while_busy", 1);

      // Reset while waiting on the selector: no pulse may follow.
      mute = 1;
      @(negedge clk) start = 1'b1;
      @(posedge clk) #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk) #1 rst = 1'b0;
      check_reset_vals("mid_reset");
      last_class = 0;
      pulses = 0;
      repeat (TMO + 4) begin
         @(posedge clk) #1;
         if (done || err) pulses++;
      end
      check("mid_reset.no_pulse", 64'(pulses), 64'd0);
      mute = 0;

      // Random trees over addresses 0..15 with small values to hit ties.
      for (int it = 0; it < 40; it++) begin
         for (int a = 0; a < 16; a++) begin
            if ($urandom_range(9) < 4) begin
               rom[a] = mk_leaf(int'($urandom_range(15)));
            end else begin
               v = int'($urandom_range(16)) - 8;
               rom[a] = mk_node(int'($urandom_range(7)), v,
                                int'($urandom_range(15)), int'($urandom_range(15)));
            end
         end
         for (int i = 0; i < 8; i++) begin
            v = int'($urandom_range(16)) - 8;
            feat[i] = v;
            err_mask[i] = ($urandom_range(15) == 0);
         end
         lat = ($urandom_range(7) == 0) ? int'($urandom_range(TMO + 1, TMO - 1))
                                        : int'($urandom_range(3, 1));
         run_inf($sformatf("rand%0d", it), bit'($urandom_range(1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
